// File: rtl/sram_pkg.sv
// Shared constants for the SRAM arbiter: FSM encoding, port ids and default bus widths.
package sram_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic PORT_VGA = 1'b0;
  localparam logic PORT_CPU = 1'b1;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 16;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant selection between the VGA and CPU ports.
// SRAM_ARB_RR_EN selects round-robin on ties; otherwise VGA has fixed priority.
module sram_arb_pick
  import sram_pkg::*;
(
  input  logic vgaReq,
  input  logic cpuReq,
  input  logic lastGrant,
  output logic grant
);

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    if (vgaReq && cpuReq) begin
      grant = ~lastGrant;
    end else if (cpuReq) begin
      grant = PORT_CPU;
    end else begin
      grant = PORT_VGA;
    end
  end
`else
  logic unusedLastGrant;
  assign unusedLastGrant = lastGrant;
  assign grant = (cpuReq && !vgaReq) ? PORT_CPU : PORT_VGA;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the async SRAM controller: VGA reader vs. CPU read/write.
// Optional round-robin arbitration via SRAM_ARB_RR_EN (see sram_arb_pick).
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iVGA_REQ,
  input  logic [ADDR_W-1:0] iVGA_ADDR,
  output logic [DATA_W-1:0] oVGA_DATA,
  output logic              oVGA_ACK,
  input  logic              iCPU_REQ,
  input  logic              iCPU_WE,
  input  logic [1:0]        iCPU_BE,
  input  logic [ADDR_W-1:0] iCPU_ADDR,
  input  logic [DATA_W-1:0] iCPU_WDATA,
  output logic [DATA_W-1:0] oCPU_RDATA,
  output logic              oCPU_ACK,
  output logic              oWE_N,
  output logic              oOE_N,
  output logic              oCE_N,
  output logic              oLB_N,
  output logic              oUB_N,
  output logic [ADDR_W-1:0] oADDR,
  output logic [DATA_W-1:0] oDATA,
  input  logic [DATA_W-1:0] iDATA
);

  localparam logic [3:0] LAST = 4'(ACC_CYCLES - 1);

  logic [1:0] stateQ, stateD;
  logic [3:0] cntQ, cntD, cntInc;
  logic       grantQ, grantD, weQ, weD;
  logic       pick, lastGrant;

  logic              weND, oeND, ceND, lbND, ubND, vgaAckD, cpuAckD;
  logic [ADDR_W-1:0] addrD;
  logic [DATA_W-1:0] dataD, vgaDataD, cpuDataD;

`ifdef SRAM_ARB_RR_EN
  // grantQ always holds the most recent grant and resets to CPU, so VGA wins the first tie.
  assign lastGrant = grantQ;
`else
  assign lastGrant = PORT_CPU;
`endif

  sram_arb_pick uPick (
    .vgaReq    (iVGA_REQ),
    .cpuReq    (iCPU_REQ),
    .lastGrant (lastGrant),
    .grant     (pick)
  );

  assign cntInc = cntQ + 4'd1;

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    grantD   = grantQ;
    weD      = weQ;
    weND     = oWE_N;
    oeND     = oOE_N;
    ceND     = oCE_N;
    lbND     = oLB_N;
    ubND     = oUB_N;
    addrD    = oADDR;
    dataD    = oDATA;
    vgaAckD  = 1'b0;
    cpuAckD  = 1'b0;
    vgaDataD = oVGA_DATA;
    cpuDataD = oCPU_RDATA;
    case (stateQ)
      IDLE: begin
        if (iVGA_REQ || iCPU_REQ) begin
          grantD = pick;
          weD    = (pick == PORT_CPU) && iCPU_WE;
          stateD = ACCESS;
          cntD   = 4'd0;
          ceND   = 1'b0;
          oeND   = weD;
          weND   = !weD;
          if (pick == PORT_CPU) begin
            addrD = iCPU_ADDR;
            lbND  = ~iCPU_BE[0];
            ubND  = ~iCPU_BE[1];
          end else begin
            addrD = iVGA_ADDR;
            lbND  = 1'b0;
            ubND  = 1'b0;
          end
          if (weD) dataD = iCPU_WDATA;
        end
      end
      ACCESS: begin
        if (cntQ == LAST) begin
          stateD = DONE;
          cntD   = 4'd0;
          {weND, oeND, ceND, lbND, ubND} = 5'b11111;
          if (grantQ == PORT_CPU) begin
            cpuAckD = 1'b1;
            if (!weQ) cpuDataD = iDATA;
          end else begin
            vgaAckD  = 1'b1;
            vgaDataD = iDATA;
          end
        end else begin
          cntD = cntInc;
          // WE_N rises one cycle before the window ends so data is held past the write edge.
          weND = !(weQ && (cntInc < LAST));
        end
      end
      DONE: stateD = IDLE;
      default: begin
        stateD = IDLE;
        {weND, oeND, ceND, lbND, ubND} = 5'b11111;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateQ     <= IDLE;
      cntQ       <= 4'd0;
      grantQ     <= PORT_CPU;
      weQ        <= 1'b0;
      oWE_N      <= 1'b1;
      oOE_N      <= 1'b1;
      oCE_N      <= 1'b1;
      oLB_N      <= 1'b1;
      oUB_N      <= 1'b1;
      oADDR      <= '0;
      oDATA      <= '0;
      oVGA_ACK   <= 1'b0;
      oCPU_ACK   <= 1'b0;
      oVGA_DATA  <= '0;
      oCPU_RDATA <= '0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      grantQ     <= grantD;
      weQ        <= weD;
      oWE_N      <= weND;
      oOE_N      <= oeND;
      oCE_N      <= ceND;
      oLB_N      <= lbND;
      oUB_N      <= ubND;
      oADDR      <= addrD;
      oDATA      <= dataD;
      oVGA_ACK   <= vgaAckD;
      oCPU_ACK   <= cpuAckD;
      oVGA_DATA  <= vgaDataD;
      oCPU_RDATA <= cpuDataD;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM on the host side.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  // Main DUT, ACC_CYCLES = 2
  logic        vgaReq = 1'b0, vgaAck, cpuReq = 1'b0, cpuWe = 1'b0, cpuAck;
  logic [1:0]  cpuBe = 2'b00;
  logic [19:0] vgaAddr = '0, cpuAddr = '0, sAddr;
  logic [15:0] vgaData, cpuWdata = '0, cpuRdata, sDout, sDin;
  logic        weN, oeN, ceN, lbN, ubN;

  // Second DUT, ACC_CYCLES = 3, VGA only
  logic        vgaReq3 = 1'b0, vgaAck3, cpuAck3;
  logic [19:0] vgaAddr3 = '0, sAddr3;
  logic [15:0] vgaData3, cpuRdata3, sDout3, sDin3;
  logic        weN3, oeN3, ceN3, lbN3, ubN3;

  sram_arbiter #(.ACC_CYCLES(2)) dut (
    .iCLK(clk), .iRST_N(rstN),
    .iVGA_REQ(vgaReq), .iVGA_ADDR(vgaAddr), .oVGA_DATA(vgaData), .oVGA_ACK(vgaAck),
    .iCPU_REQ(cpuReq), .iCPU_WE(cpuWe), .iCPU_BE(cpuBe), .iCPU_ADDR(cpuAddr),
    .iCPU_WDATA(cpuWdata), .oCPU_RDATA(cpuRdata), .oCPU_ACK(cpuAck),
    .oWE_N(weN), .oOE_N(oeN), .oCE_N(ceN), .oLB_N(lbN), .oUB_N(ubN),
    .oADDR(sAddr), .oDATA(sDout), .iDATA(sDin)
  );

  sram_arbiter #(.ACC_CYCLES(3)) dut3 (
    .iCLK(clk), .iRST_N(rstN),
    .iVGA_REQ(vgaReq3), .iVGA_ADDR(vgaAddr3), .oVGA_DATA(vgaData3), .oVGA_ACK(vgaAck3),
    .iCPU_REQ(1'b0), .iCPU_WE(1'b0), .iCPU_BE(2'b00), .iCPU_ADDR(20'h0),
    .iCPU_WDATA(16'h0), .oCPU_RDATA(cpuRdata3), .oCPU_ACK(cpuAck3),
    .oWE_N(weN3), .oOE_N(oeN3), .oCE_N(ceN3), .oLB_N(lbN3), .oUB_N(ubN3),
    .oADDR(sAddr3), .oDATA(sDout3), .iDATA(sDin3)
  );

  // Byte-masked SRAM model, written on the clock edge while CE_N and WE_N are low
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    if (!ceN && !weN) begin
      if (!lbN) mem[sAddr[11:0]][7:0]  <= sDout[7:0];
      if (!ubN) mem[sAddr[11:0]][15:8] <= sDout[15:8];
    end
  end
  assign sDin  = (!ceN && !oeN) ? mem[sAddr[11:0]] : 16'h0000;
  assign sDin3 = (!ceN3 && !oeN3) ? {4'hC, sAddr3[11:0]} : 16'h0000;

  int tests = 0;
  int fails = 0;
  int bothAck = 0;

  always @(negedge clk) if (vgaAck && cpuAck) bothAck++;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpuAccess(input logic we, input logic [1:0] be, input logic [19:0] addr,
                           input logic [15:0] wdata, input bit glitch,
                           output logic [15:0] rdata, output int lat, output int weLow,
                           output bit lbLow, output bit ubLow);
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = we; cpuBe = be; cpuAddr = addr; cpuWdata = wdata;
    lat = 0; weLow = 0; lbLow = 1'b0; ubLow = 1'b0; rdata = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!weN) weLow++;
      if (!lbN) lbLow = 1'b1;
      if (!ubN) ubLow = 1'b1;
      if (glitch && k == 1) begin
        cpuAddr = 20'h00FFF; cpuWdata = 16'hDEAD; cpuWe = ~we;
      end
      if (glitch && k == 2) checkVal("addrHeld", 32'(sAddr), 32'(addr));
      if (cpuAck) begin
        lat = k; rdata = cpuRdata;
        break;
      end
    end
    cpuReq = 1'b0;
    checkVal("cpuAckSeen", 32'(lat != 0), 32'd1);
  endtask

  task automatic pairAccess(input bit doVga, input bit doCpu, input logic [19:0] vAddr,
                            input logic [19:0] cAddr, output int tV, output int tC,
                            output logic [15:0] dV, output logic [15:0] dC);
    @(negedge clk);
    vgaReq = doVga; vgaAddr = vAddr;
    cpuReq = doCpu; cpuWe = 1'b0; cpuBe = 2'b11; cpuAddr = cAddr;
    tV = 0; tC = 0; dV = '0; dC = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (vgaAck) begin tV = k; dV = vgaData; vgaReq = 1'b0; end
      if (cpuAck) begin tC = k; dC = cpuRdata; cpuReq = 1'b0; end
      if ((tV != 0 || !doVga) && (tC != 0 || !doCpu)) break;
    end
    vgaReq = 1'b0; cpuReq = 1'b0;
  endtask

  initial begin
    logic [15:0] rd, dV, dC;
    int lat, wl, tV, tC, ackSeen, expV, expC, nAck;
    int ackT [3];
    bit lb, ub;

    // Reset state
    repeat (2) @(negedge clk);
    checkVal("rstStrobes", 32'({weN, oeN, ceN, lbN, ubN}), 32'h1f);
    checkVal("rstAddr", 32'(sAddr), 32'h0);
    checkVal("rstData", 32'(sDout), 32'h0);
    checkVal("rstAcks", 32'({vgaAck, cpuAck}), 32'h0);
    checkVal("rstRdata", 32'({vgaData, cpuRdata}), 32'h0);
    checkVal("rst3Strobes", 32'({weN3, oeN3, ceN3, lbN3, ubN3}), 32'h1f);
    rstN = 1'b1;

    // Reset in the middle of a CPU write window
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = 1'b1; cpuBe = 2'b11; cpuAddr = 20'h00300; cpuWdata = 16'h1111;
    @(negedge clk);
    checkVal("preRstCe", 32'(ceN), 32'h0);
    #2 rstN = 1'b0;
    #1 checkVal("midRstStrobes", 32'({weN, oeN, ceN, lbN, ubN}), 32'h1f);
    checkVal("midRstAddr", 32'(sAddr), 32'h0);
    cpuReq = 1'b0;
    ackSeen = 0;
    repeat (2) begin @(negedge clk); if (cpuAck || vgaAck) ackSeen++; end
    rstN = 1'b1;
    repeat (4) begin @(negedge clk); if (cpuAck || vgaAck) ackSeen++; end
    checkVal("midRstNoAck", 32'(ackSeen), 32'h0);

    // Full-word write then read
    cpuAccess(1'b1, 2'b11, 20'h00123, 16'hBEEF, 1'b0, rd, lat, wl, lb, ub);
    checkVal("wrLatency", 32'(lat), 32'd3);
    checkVal("wrWeLowCycles", 32'(wl), 32'd1);
    cpuAccess(1'b0, 2'b11, 20'h00123, 16'h0000, 1'b0, rd, lat, wl, lb, ub);
    checkVal("rdData", 32'(rd), 32'hBEEF);
    checkVal("rdLatency", 32'(lat), 32'd3);
    checkVal("rdNoWe", 32'(wl), 32'd0);

    // Lower-byte write
    cpuAccess(1'b1, 2'b01, 20'h00123, 16'h55AA, 1'b0, rd, lat, wl, lb, ub);
    checkVal("byteLbLow", 32'(lb), 32'd1);
    checkVal("byteUbHigh", 32'(ub), 32'd0);
    cpuAccess(1'b0, 2'b11, 20'h00123, 16'h0000, 1'b0, rd, lat, wl, lb, ub);
    checkVal("byteReadback", 32'(rd), 32'hBEAA);

    // Write with no byte enables: full window, acked, memory untouched
    cpuAccess(1'b1, 2'b00, 20'h00123, 16'h0000, 1'b0, rd, lat, wl, lb, ub);
    checkVal("be0Latency", 32'(lat), 32'd3);
    checkVal("be0WePulse", 32'(wl), 32'd1);
    checkVal("be0NoBytes", 32'({lb, ub}), 32'h0);

    // Inputs changed mid-access are ignored
    cpuAccess(1'b0, 2'b11, 20'h00123, 16'h0000, 1'b1, rd, lat, wl, lb, ub);
    checkVal("glitchRdData", 32'(rd), 32'hBEAA);
    checkVal("glitchNoWe", 32'(wl), 32'd0);

    // Preload words for the VGA reads
    cpuAccess(1'b1, 2'b11, 20'h00010, 16'hA5A5, 1'b0, rd, lat, wl, lb, ub);
    cpuAccess(1'b1, 2'b11, 20'h00020, 16'h5A5A, 1'b0, rd, lat, wl, lb, ub);

    // Simultaneous requests: VGA wins the first tie in either arbitration mode
    pairAccess(1'b1, 1'b1, 20'h00010, 20'h00020, tV, tC, dV, dC);
    checkVal("tie1VgaAck", 32'(tV), 32'd3);
    checkVal("tie1CpuAck", 32'(tC), 32'd7);
    checkVal("tie1VgaData", 32'(dV), 32'hA5A5);
    checkVal("tie1CpuData", 32'(dC), 32'h5A5A);

    // Lone VGA read leaves VGA as the last grant
    pairAccess(1'b1, 1'b0, 20'h00020, 20'h00000, tV, tC, dV, dC);
    checkVal("loneVgaAck", 32'(tV), 32'd3);
    checkVal("loneVgaData", 32'(dV), 32'h5A5A);

    pairAccess(1'b1, 1'b1, 20'h00010, 20'h00020, tV, tC, dV, dC);
`ifdef SRAM_ARB_RR_EN
    expV = 7; expC = 3;
`else
    expV = 3; expC = 7;
`endif
    checkVal("tie2VgaAck", 32'(tV), 32'(expV));
    checkVal("tie2CpuAck", 32'(tC), 32'(expC));
    checkVal("neverBothAck", 32'(bothAck), 32'h0);

    // Back-to-back VGA on the ACC_CYCLES = 3 instance
    @(negedge clk);
    vgaReq3 = 1'b1; vgaAddr3 = 20'h00077;
    nAck = 0;
    ackT = '{0, 0, 0};
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (vgaAck3) begin
        ackT[nAck] = k;
        nAck++;
        checkVal("b2bDoneStrobes", 32'({weN3, oeN3, ceN3, lbN3, ubN3}), 32'h1f);
        checkVal("b2bVgaData", 32'(vgaData3), 32'hC077);
        checkVal("b2bNoCpuAck", 32'(cpuAck3), 32'h0);
        if (nAck == 3) break;
      end
    end
    vgaReq3 = 1'b0;
    checkVal("b2bAckCount", 32'(nAck), 32'd3);
    checkVal("b2bFirstAck", 32'(ackT[0]), 32'd4);
    checkVal("b2bSpacing1", 32'(ackT[1] - ackT[0]), 32'd5);
    checkVal("b2bSpacing2", 32'(ackT[2] - ackT[1]), 32'd5);
    checkVal("dut3Idle", 32'({cpuRdata3, sDout3}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
